// File: rtl/hdmi_video_timing_ctrl.sv
// hdmi_video_timing_ctrl: HDMI sync/DE/pixel-request generator with shadowed timing applied on frame boundaries
module hdmi_video_timing_ctrl #(
  parameter int   CW       = 12,
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_pending,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic          pix_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          video_hs,
  output logic          video_vs,
  output logic          video_de,
  output logic          frame_start
);
  localparam int XW = CW + 2;
  // register map: 0..3 = h active/fp/sync/bp, 4..7 = v active/fp/sync/bp
  localparam logic [CW-1:0] P_INIT [8] = '{CW'(H_ACTIVE), CW'(H_FP), CW'(H_SYNC), CW'(H_BP),
                                           CW'(V_ACTIVE), CW'(V_FP), CW'(V_SYNC), CW'(V_BP)};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_act [8];
  logic [CW-1:0] r_shd [8];
  logic [CW-1:0] r_h, r_v;
  logic          r_pending, r_err, r_de, r_hs, r_vs, r_fs;
  logic [XW-1:0] w_ht, w_vt, w_sht, w_svt, w_ha0, w_ha1, w_va0, w_va1;
  logic          w_run, w_h_end, w_fend, w_apply, w_ok, w_hin, w_vin;
  assign w_ht  = XW'(r_act[0]) + XW'(r_act[1]) + XW'(r_act[2]) + XW'(r_act[3]);
  assign w_vt  = XW'(r_act[4]) + XW'(r_act[5]) + XW'(r_act[6]) + XW'(r_act[7]);
  assign w_sht = XW'(r_shd[0]) + XW'(r_shd[1]) + XW'(r_shd[2]) + XW'(r_shd[3]);
  assign w_svt = XW'(r_shd[4]) + XW'(r_shd[5]) + XW'(r_shd[6]) + XW'(r_shd[7]);
  assign w_ha0 = XW'(r_act[2]) + XW'(r_act[3]);
  assign w_ha1 = w_ha0 + XW'(r_act[0]);
  assign w_va0 = XW'(r_act[6]) + XW'(r_act[7]);
  assign w_va1 = w_va0 + XW'(r_act[4]);
  assign w_ok  = |r_shd[0] && |r_shd[4] && |r_shd[2] && |r_shd[6] &&
                 w_sht[XW-1:CW] == '0 && w_svt[XW-1:CW] == '0;
  assign w_run   = r_state != IDLE;
  assign w_h_end = XW'(r_h) == w_ht - XW'(1);
  assign w_fend  = w_h_end && XW'(r_v) == w_vt - XW'(1);
  // outside a frame there is nothing to disturb, so IDLE applies a staged set at once
  assign w_apply = r_pending && (!w_run || w_fend);
  assign w_hin   = XW'(r_h) >= w_ha0 && XW'(r_h) < w_ha1;
  assign w_vin   = XW'(r_v) >= w_va0 && XW'(r_v) < w_va1;
  assign pix_req = w_run && w_hin && w_vin;
  assign pix_x   = pix_req ? r_h - w_ha0[CW-1:0] : '0;
  assign pix_y   = pix_req ? r_v - w_va0[CW-1:0] : '0;
  assign cfg_pending = r_pending;
  assign cfg_done    = w_apply;
  assign cfg_err     = r_err;
  assign video_de    = r_de;
  assign video_hs    = r_hs;
  assign video_vs    = r_vs;
  assign frame_start = r_fs;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (en ? RUN : IDLE) :
             r_state == RUN  ? (en ? RUN : DRAIN) :
             (en ? RUN : w_fend ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h       <= '0;
      r_v       <= '0;
      r_act     <= P_INIT;
      r_shd     <= P_INIT;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_de      <= 1'b0;
      r_hs      <= !HS_POL;
      r_vs      <= !VS_POL;
      r_fs      <= 1'b0;
    end else begin
      r_h <= (!w_run || w_h_end) ? '0 : r_h + CW'(1);
      r_v <= (!w_run || w_fend) ? '0 : w_h_end ? r_v + CW'(1) : r_v;
      if (w_apply) r_act <= r_shd;
      if (cfg_wr) r_shd[cfg_addr] <= cfg_data;
      r_pending <= (cfg_commit && w_ok) || (r_pending && !w_apply);
      r_err     <= cfg_commit && !w_ok;
      r_de      <= pix_req;
      r_hs      <= (w_run && r_h < r_act[2]) ? HS_POL : !HS_POL;
      r_vs      <= (w_run && r_v < r_act[6]) ? VS_POL : !VS_POL;
      r_fs      <= pix_req && pix_x == '0 && pix_y == '0;
    end
  end
endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// tb_hdmi_video_timing_ctrl: directed stimulus with queued expectations checked by a negedge monitor
module tb_hdmi_video_timing_ctrl;
  logic        clk = 1'b0, rst, en, cfg_wr, cfg_commit;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        cfg_pending, cfg_done, cfg_err, pix_req, video_hs, video_vs, video_de, frame_start;
  logic [11:0] pix_x, pix_y;
  int          cyc = 0, n_chk = 0, n_fail = 0, c0, c1, hs_run;
  logic        prev_pix;
  logic [23:0] e;
  logic [23:0] q_pix[$];
  int          q_fs[$], q_done[$], q_err[$];

  hdmi_video_timing_ctrl #(
    .CW(12), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .video_hs(video_hs), .video_vs(video_vs),
    .video_de(video_de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int ha);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < ha; x++) q_pix.push_back({12'(x), 12'(y)});
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [11:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_pix = 1'b0;
      hs_run   = 0;
    end else begin
      if (pix_req) begin
        if (q_pix.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL pix_unexpected: got x=%0d y=%0d at cyc %0d, expected no request", pix_x, pix_y, cyc);
        end else begin
          e = q_pix.pop_front();
          chk("pix_xy", {8'd0, pix_x, pix_y}, {8'd0, e});
        end
      end else chk("pix_zero", {8'd0, pix_x, pix_y}, 32'd0);
      chk("de_latency", {31'd0, video_de}, {31'd0, prev_pix});
      prev_pix = pix_req;
      if (video_hs) hs_run++;
      else if (hs_run > 0) begin
        chk("hs_width", hs_run, 2);
        hs_run = 0;
      end
      if (frame_start) begin
        if (q_fs.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL frame_start: got pulse at cyc %0d, expected none", cyc);
        end else chk("frame_start_cyc", cyc, q_fs.pop_front());
      end
      if (cfg_done) begin
        if (q_done.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cfg_done: got pulse at cyc %0d, expected none", cyc);
        end else chk("cfg_done_cyc", cyc, q_done.pop_front());
      end
      if (cfg_err) begin
        if (q_err.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cfg_err: got pulse at cyc %0d, expected none", cyc);
        end else chk("cfg_err_cyc", cyc, q_err.pop_front());
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pix_req"}, pix_req, 0);
    chk({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
    chk({tag, "_de"}, video_de, 0);
    chk({tag, "_hs"}, video_hs, 0);
    chk({tag, "_vs"}, video_vs, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_pending"}, cfg_pending, 0);
    chk({tag, "_done"}, cfg_done, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    c0 = cyc;
    push_frame(8); push_frame(8);
    q_fs.push_back(c0 + 34); q_fs.push_back(c0 + 132);
    rst = 1'b0; en = 1'b1;
    wait_to(c0 + 2);
    chk("line0_hs", video_hs, 1); chk("line0_vs", video_vs, 1); chk("line0_de", video_de, 0);
    wait_to(c0 + 4);
    chk("bp_hs", video_hs, 0); chk("bp_vs", video_vs, 1);
    wait_to(c0 + 16);
    chk("line1_hs", video_hs, 1); chk("line1_vs", video_vs, 0);
    wait_to(c0 + 140);
    cfg_write(3'd0, 12'd4);
    cfg_commit = 1'b1;
    push_frame(4); push_frame(4);
    q_done.push_back(c0 + 196);
    q_fs.push_back(c0 + 222); q_fs.push_back(c0 + 292);
    @(negedge clk);
    cfg_commit = 1'b0;
    wait_to(c0 + 150); chk("pending_mid", cfg_pending, 1);
    wait_to(c0 + 196); chk("pending_at_end", cfg_pending, 1);
    wait_to(c0 + 197); chk("pending_cleared", cfg_pending, 0);
    wait_to(c0 + 230);
    cfg_write(3'd6, 12'd0);
    cfg_commit = 1'b1;
    q_err.push_back(c0 + 232);
    @(negedge clk);
    cfg_commit = 1'b0;
    cfg_write(3'd6, 12'd1);
    wait_to(c0 + 235); chk("err_not_staged", cfg_pending, 0);
    wait_to(c0 + 280);
    en = 1'b0;
    wait_to(c0 + 345);
    chk("drain_pix_req", pix_req, 0); chk("drain_de", video_de, 0);
    chk("drain_hs", video_hs, 0); chk("drain_vs", video_vs, 0);
    wait_to(c0 + 350);
    en = 1'b1;
    push_frame(4);
    q_fs.push_back(c0 + 376);
    wait_to(c0 + 380);
    cfg_write(3'd0, 12'd6);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    wait_to(c0 + 390); chk("pending_before_rst", cfg_pending, 1);
    wait_to(c0 + 397);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("async_rst");
    q_pix.delete();
    wait_to(c0 + 400);
    c1 = cyc;
    push_frame(8);
    q_fs.push_back(c1 + 34);
    rst = 1'b0;
    wait_to(c1 + 2); chk("pending_after_rst", cfg_pending, 0);
    wait_to(c1 + 120);
    chk("pix_left", q_pix.size(), 0);
    chk("fs_left", q_fs.size(), 0);
    chk("done_left", q_done.size(), 0);
    chk("err_left", q_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end
endmodule
